// File: rtl/counter_trigger_sequencer_if.sv
// Counter-side link of the trigger sequencer: period ticks and lengths come
// in from the period counter, arm/release pulses and the averaged reference
// go back out to it.
interface counter_trigger_sequencer_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic                     period_tick;
  logic [COUNTER_WIDTH-1:0] last_counter;
  logic                     trigger_armed;
  logic                     trigger_arm;
  logic                     trigger_reset;
  logic [COUNTER_WIDTH-1:0] reference_counter;

  // Sequencer side
  modport master (
    input  period_tick, last_counter, trigger_armed,
    output trigger_arm, trigger_reset, reference_counter
  );

  // Delayed-trigger counter side
  modport slave (
    output period_tick, last_counter, trigger_armed,
    input  trigger_arm, trigger_reset, reference_counter
  );
endinterface

// File: rtl/counter_trigger_sequencer.sv
// Sequencer for the counter-delayed trigger datapath: settles on the period
// counter, averages 2^avg_log2 period lengths into reference_counter, then
// arms the trigger, holds it and releases it with a single reset pulse.
module counter_trigger_sequencer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int TIMEOUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     abort,
  input  logic [2:0]               avg_log2,
  input  logic [TIMEOUT_WIDTH-1:0] hold_cycles,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic                     busy,
  output logic                     error,
  output logic [2:0]               state,
  counter_trigger_sequencer_if.master cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_ARM     = 3'd3,
    S_ARMED   = 3'd4,
    S_RELEASE = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  // Seven spare bits hold up to 128 full-scale samples without overflow.
  localparam int ACC_W = COUNTER_WIDTH + 7;
  localparam logic [TIMEOUT_WIDTH-1:0] ONE = TIMEOUT_WIDTH'(1);

  state_t                   state_q;
  logic [ACC_W-1:0]         acc_p1;
  logic [7:0]               smp_cnt;
  logic [2:0]               avg_q;
  logic                     settle_seen;
  logic                     vld_p1;
  logic                     done_p2;
  logic                     arm_sent;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic [TIMEOUT_WIDTH-1:0] hold_cnt;
  logic [COUNTER_WIDTH-1:0] ref_q;
  logic                     arm_q;
  logic                     rel_q;
  logic                     err_q;

  logic timeout_hit;
  logic hold_hit;
  logic last_sample;

  // Truncating average: drop the low avg_log2 bits of the window sum.
  function automatic logic [COUNTER_WIDTH-1:0] avg_trunc(
    input logic [ACC_W-1:0] acc,
    input logic [2:0]       sh
  );
    logic [ACC_W-1:0] q;
    q = acc >> sh;
    return q[COUNTER_WIDTH-1:0];
  endfunction

  assign timeout_hit = (timeout_cycles != '0) && (timer == timeout_cycles - ONE);
  assign hold_hit    = (hold_cycles != '0) && (hold_cnt == hold_cycles - ONE);
  assign last_sample = (smp_cnt == ((8'd1 << avg_q) - 8'd1));

  assign busy                  = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign error                 = err_q;
  assign state                 = state_q;
  assign cnt.trigger_arm       = arm_q;
  assign cnt.trigger_reset     = rel_q;
  assign cnt.reference_counter = ref_q;

  // Sequencer FSM with its accumulator, timers and registered pulse outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      acc_p1      <= '0;
      smp_cnt     <= '0;
      avg_q       <= '0;
      settle_seen <= 1'b0;
      vld_p1      <= 1'b0;
      done_p2     <= 1'b0;
      arm_sent    <= 1'b0;
      timer       <= '0;
      hold_cnt    <= '0;
      ref_q       <= '0;
      arm_q       <= 1'b0;
      rel_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (!enable) begin
      // Disable drops straight to IDLE; the counter resets itself, so no release pulse.
      state_q     <= S_IDLE;
      acc_p1      <= '0;
      smp_cnt     <= '0;
      settle_seen <= 1'b0;
      vld_p1      <= 1'b0;
      done_p2     <= 1'b0;
      arm_sent    <= 1'b0;
      timer       <= '0;
      hold_cnt    <= '0;
      ref_q       <= '0;
      arm_q       <= 1'b0;
      rel_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      arm_q  <= 1'b0;
      rel_q  <= 1'b0;
      // p0 -> p1: a measuring tick qualifies last_counter on the following cycle
      vld_p1 <= cnt.period_tick && (state_q == S_MEASURE);
      unique case (state_q)
        S_IDLE, S_ERROR: begin
          if (abort) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (start) begin
            err_q       <= 1'b0;
            state_q     <= S_SETTLE;
            acc_p1      <= '0;
            smp_cnt     <= '0;
            timer       <= '0;
            settle_seen <= 1'b0;
            done_p2     <= 1'b0;
            avg_q       <= avg_log2;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state_q <= S_RELEASE;
            rel_q   <= 1'b1;
          end else if (cnt.period_tick) begin
            timer       <= '0;
            settle_seen <= 1'b1;
            if (settle_seen) state_q <= S_MEASURE;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            timer <= timer + ONE;
          end
        end
        S_MEASURE: begin
          if (abort) begin
            state_q <= S_RELEASE;
            rel_q   <= 1'b1;
          end else if (done_p2) begin
            // p2: window complete, publish the average and move on to arming
            ref_q    <= avg_trunc(acc_p1, avg_q);
            state_q  <= S_ARM;
            timer    <= '0;
            arm_sent <= 1'b0;
            done_p2  <= 1'b0;
          end else begin
            // p1 -> p2: fold the sample into the window sum
            if (vld_p1) begin
              acc_p1  <= acc_p1 + {7'd0, cnt.last_counter};
              smp_cnt <= smp_cnt + 8'd1;
              done_p2 <= last_sample;
            end
            if (cnt.period_tick) begin
              timer <= '0;
            end else if (timeout_hit) begin
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end else begin
              timer <= timer + ONE;
            end
          end
        end
        S_ARM: begin
          if (abort) begin
            state_q <= S_RELEASE;
            rel_q   <= 1'b1;
          end else if (!arm_sent) begin
            arm_q    <= 1'b1;
            arm_sent <= 1'b1;
          end else if (cnt.trigger_armed) begin
            state_q  <= S_ARMED;
            hold_cnt <= '0;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            timer <= timer + ONE;
          end
        end
        S_ARMED: begin
          if (abort || hold_hit) begin
            state_q <= S_RELEASE;
            rel_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + ONE;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_trigger_sequencer.sv
// Directed-plus-random bench for counter_trigger_sequencer. A small counter
// model answers arm pulses; expected averages come from plain arithmetic on
// the sample table.
module tb_counter_trigger_sequencer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        start;
  logic        abort;
  logic [2:0]  avg_log2;
  logic [31:0] hold_cycles;
  logic [31:0] timeout_cycles;
  logic        busy;
  logic        error;
  logic [2:0]  state;

  counter_trigger_sequencer_if #(.COUNTER_WIDTH(32)) cif();

  counter_trigger_sequencer #(
    .COUNTER_WIDTH(32),
    .TIMEOUT_WIDTH(32)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .enable         (enable),
    .start          (start),
    .abort          (abort),
    .avg_log2       (avg_log2),
    .hold_cycles    (hold_cycles),
    .timeout_cycles (timeout_cycles),
    .busy           (busy),
    .error          (error),
    .state          (state),
    .cnt            (cif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_arm = 0;
  int n_rst = 0;
  int arm_cyc = 0;
  int rst_cyc = 0;
  int armed_cyc = 0;
  int tick_cyc = 0;
  logic [2:0] prev_state = 3'd0;
  int ncmp = 0;
  int nfail = 0;
  logic armed_r;
  logic [31:0] samp [128];

  always @(posedge clk) cyc <= cyc + 1;

  // Counter model: becomes armed on an arm pulse, disarms on a release pulse.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) armed_r <= 1'b0;
    else if (cif.trigger_arm === 1'b1) armed_r <= 1'b1;
    else if (cif.trigger_reset === 1'b1) armed_r <= 1'b0;
  end
  assign cif.trigger_armed = armed_r;

  // Pulse and state-entry monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (cif.trigger_arm === 1'b1) begin
      n_arm   <= n_arm + 1;
      arm_cyc <= cyc;
    end
    if (cif.trigger_reset === 1'b1) begin
      n_rst   <= n_rst + 1;
      rst_cyc <= cyc;
    end
    if (state == 3'd4 && prev_state != 3'd4) armed_cyc <= cyc;
    prev_state <= state;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle period tick; the period length follows on the next cycle.
  task automatic do_tick(input logic [31:0] value);
    cif.period_tick = 1'b1;
    step(1);
    tick_cyc = cyc;
    cif.period_tick = 1'b0;
    cif.last_counter = value;
  endtask

  // Reference: mean of the first 2^n samples, rounded toward zero.
  function automatic logic [31:0] model_avg(input int n);
    longint unsigned sum;
    longint unsigned cnt;
    sum = 0;
    cnt = longint'(1) << n;
    for (int i = 0; i < int'(cnt); i++) sum += longint'(samp[i]);
    return 32'(sum / cnt);
  endfunction

  task automatic run_seq(input string tag, input int n, input int gap, input int hold);
    int base_arm;
    int base_rst;
    int tcyc;
    logic [31:0] exp_ref;
    exp_ref  = model_avg(n);
    base_arm = n_arm;
    base_rst = n_rst;
    avg_log2 = 3'(n);
    hold_cycles = 32'(hold);
    start = 1'b1; step(1); start = 1'b0;
    check({tag, " enter_settle"}, 64'(state), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd1);
    avg_log2 = ~(3'(n));
    start = 1'b1; step(1); start = 1'b0;
    check({tag, " start_ignored"}, 64'(state), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step(gap - 1);
      do_tick($urandom);
    end
    check({tag, " enter_measure"}, 64'(state), 64'd2);
    for (int i = 0; i < (1 << n); i++) begin
      step(gap - 1);
      do_tick(samp[i]);
    end
    tcyc = tick_cyc;
    step(2);
    check({tag, " ref_value"}, 64'(cif.reference_counter), 64'(exp_ref));
    check({tag, " enter_arm"}, 64'(state), 64'd3);
    step(2);
    check({tag, " arm_count"}, 64'(n_arm - base_arm), 64'd1);
    check({tag, " arm_latency"}, 64'(arm_cyc - tcyc), 64'd3);
    for (int k = 0; k < 50 && state != 3'd4; k++) step(1);
    check({tag, " enter_armed"}, 64'(state), 64'd4);
    if (hold != 0) begin
      for (int k = 0; k < hold + 20 && n_rst == base_rst; k++) step(1);
      check({tag, " rst_count"}, 64'(n_rst - base_rst), 64'd1);
      check({tag, " hold_time"}, 64'(rst_cyc - armed_cyc), 64'(hold));
    end else begin
      step(10000);
      check({tag, " still_armed"}, 64'(state), 64'd4);
      check({tag, " no_release"}, 64'(n_rst - base_rst), 64'd0);
      abort = 1'b1; step(1); abort = 1'b0;
      check({tag, " abort_release"}, 64'(cif.trigger_reset), 64'd1);
      step(1);
      check({tag, " rst_count"}, 64'(n_rst - base_rst), 64'd1);
    end
    check({tag, " idle"}, 64'(state), 64'd0);
    check({tag, " not_busy"}, 64'(busy), 64'd0);
    check({tag, " ref_kept"}, 64'(cif.reference_counter), 64'(exp_ref));
    check({tag, " single_arm"}, 64'(n_arm - base_arm), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_arm;
    int base_rst;
    aresetn = 1'b0;
    enable = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    avg_log2 = 3'd0;
    hold_cycles = 32'd0;
    timeout_cycles = 32'd0;
    cif.period_tick = 1'b0;
    cif.last_counter = 32'd0;
    step(3);
    check("reset state", 64'(state), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset error", 64'(error), 64'd0);
    check("reset ref", 64'(cif.reference_counter), 64'd0);
    check("reset arm", 64'(cif.trigger_arm), 64'd0);
    check("reset release", 64'(cif.trigger_reset), 64'd0);
    aresetn = 1'b1;
    enable = 1'b1;
    step(2);

    // Steady 999-cycle periods, 1000 cycles apart.
    for (int i = 0; i < 128; i++) samp[i] = 32'd999;
    run_seq("steady", 2, 1000, 50);

    // Asynchronous reset mid-measurement.
    base_arm = n_arm;
    base_rst = n_rst;
    avg_log2 = 3'd2;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4);
      do_tick(32'd55);
    end
    step(1);
    check("pre_reset measure", 64'(state), 64'd2);
    #2 aresetn = 1'b0;
    #1;
    check("async state", 64'(state), 64'd0);
    check("async busy", 64'(busy), 64'd0);
    check("async ref", 64'(cif.reference_counter), 64'd0);
    check("async error", 64'(error), 64'd0);
    step(3);
    aresetn = 1'b1;
    step(50);
    check("post_reset idle", 64'(state), 64'd0);
    check("post_reset no_arm", 64'(n_arm - base_arm), 64'd0);
    check("post_reset no_release", 64'(n_rst - base_rst), 64'd0);

    // Average of a short varying window.
    samp[0] = 32'd100; samp[1] = 32'd102; samp[2] = 32'd98; samp[3] = 32'd104;
    run_seq("avg101", 2, 8, 5);

    // Ticks stop during MEASURE with a 500-cycle timeout.
    base_arm = n_arm;
    timeout_cycles = 32'd500;
    avg_log2 = 3'd2;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(19);
      do_tick(32'd10);
    end
    step(499);
    check("timeout not_yet", 64'(state), 64'd2);
    check("timeout no_error_yet", 64'(error), 64'd0);
    step(1);
    check("timeout state", 64'(state), 64'd6);
    check("timeout error", 64'(error), 64'd1);
    check("timeout busy", 64'(busy), 64'd0);
    step(5);
    check("timeout no_arm", 64'(n_arm - base_arm), 64'd0);
    start = 1'b1; step(1); start = 1'b0;
    check("restart clears error", 64'(error), 64'd0);
    check("restart settle", 64'(state), 64'd1);
    enable = 1'b0; step(1); enable = 1'b1;
    check("disable idle", 64'(state), 64'd0);
    timeout_cycles = 32'd0;
    step(2);

    // Hold until abort, random window contents.
    for (int i = 0; i < 128; i++) samp[i] = $urandom;
    run_seq("hold_forever", $urandom_range(0, 3), 4, 0);

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1; step(1); start = 1'b0; abort = 1'b0;
    check("start_abort state", 64'(state), 64'd0);
    step(1);
    check("start_abort stays", 64'(state), 64'd0);
    check("start_abort busy", 64'(busy), 64'd0);

    // Full-scale samples over the largest window.
    for (int i = 0; i < 128; i++) samp[i] = 32'hFFFF_FFFF;
    run_seq("fullscale", 7, 3, 4);

    // Random windows, gaps and hold times.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 128; i++) samp[i] = $urandom;
      run_seq($sformatf("rand%0d", r), $urandom_range(0, 4), $urandom_range(2, 6),
              $urandom_range(1, 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
